// File: rtl/sparse_cnn_pkg.sv
// Shared parameters, types and index helper for the sparse convolution engine.
// Optional bias initialisation is selected with the SPARSE_CNN_BIAS_EN macro.
// No logic here; imported by sparse_cnn and sparse_cnn_pe.
package sparse_cnn_pkg;

  localparam int WORD_LENGTH = 8;
  localparam int IMAGE_SIZE  = 28;
  localparam int KERNEL_SIZE = 5;
  localparam int OUTPUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int MAX_NNZ     = 28;
  localparam int ACC_WIDTH   = 16;
  localparam int NUM_OUT     = OUTPUT_SIZE * OUTPUT_SIZE;

  // 10 bits address the 576 accumulators, 5 bits hold a row/col up to 27
  localparam int IDX_W = 10;
  localparam int CNT_W = 5;

  localparam logic [ACC_WIDTH-1:0] BIAS = 16'd14;

  typedef logic        [WORD_LENGTH-1:0] pixel_t;
  typedef logic signed [WORD_LENGTH-1:0] weight_t;
  typedef logic signed [ACC_WIDTH-1:0]   acc_t;
  typedef logic        [IDX_W-1:0]       idx_t;
  typedef logic        [CNT_W-1:0]       cnt_t;

  // Value every accumulator takes at reset and at the start of each frame
`ifdef SPARSE_CNN_BIAS_EN
  localparam acc_t ACC_INIT = acc_t'(BIAS);
`else
  localparam acc_t ACC_INIT = '0;
`endif

  // Row-major flat index of an output position
  function automatic idx_t flat_idx(input cnt_t oy, input cnt_t ox);
    return idx_t'(oy) * idx_t'(OUTPUT_SIZE) + idx_t'(ox);
  endfunction

endpackage

// File: rtl/sparse_cnn_pe.sv
// One weight slot: turns the current pixel into a product and the output it lands on.
// Purely combinational, zero latency.
// No backpressure; the top decides when the result is used.
module sparse_cnn_pe
  import sparse_cnn_pkg::*;
(
  input  logic                   en_i,
  input  logic [WORD_LENGTH-1:0] pixel_i,
  input  logic [WORD_LENGTH-1:0] weight_i,
  input  logic [WORD_LENGTH-1:0] row_i,
  input  logic [WORD_LENGTH-1:0] col_i,
  input  logic [CNT_W-1:0]       r_i,
  input  logic [CNT_W-1:0]       c_i,
  output logic [ACC_WIDTH-1:0]   prod_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   hit_o
);

  logic [8:0]                  dy;
  logic [8:0]                  dx;
  logic                        oy_ok;
  logic                        ox_ok;
  logic                        tap_ok;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] p_ext;

  // Target position (r-row, c-col); a borrow out of the 9-bit subtract sets bit 8,
  // so negative offsets show up as a set MSB and fail the range test.
  always_comb begin
    dy     = {4'b0, r_i} - {1'b0, row_i};
    dx     = {4'b0, c_i} - {1'b0, col_i};
    oy_ok  = !dy[8] && (dy[7:0] < 8'(OUTPUT_SIZE));
    ox_ok  = !dx[8] && (dx[7:0] < 8'(OUTPUT_SIZE));
    tap_ok = (row_i < 8'(KERNEL_SIZE)) && (col_i < 8'(KERNEL_SIZE));
    hit_o  = en_i && tap_ok && oy_ok && ox_ok;
    idx_o  = flat_idx(dy[CNT_W-1:0], dx[CNT_W-1:0]);
  end

  // Signed weight times unsigned pixel; 16-bit truncation equals the
  // sign-extended 9x8 product since the exact result fits in 16 bits.
  always_comb begin
    w_ext  = {{(ACC_WIDTH-WORD_LENGTH){weight_i[WORD_LENGTH-1]}}, weight_i};
    p_ext  = {{(ACC_WIDTH-WORD_LENGTH){1'b0}}, pixel_i};
    prod_o = w_ext * p_ext;
  end

endmodule

// File: rtl/sparse_cnn.sv
// Sparse COO-kernel 2-D valid convolution, scatter-accumulating a 28x28 frame into 24x24 sums.
// Each accepted pixel updates all taps in the same cycle; out_valid rises on the last pixel's edge.
// No backpressure: every feature_in_valid beat is consumed. Bias init via SPARSE_CNN_BIAS_EN.
module sparse_cnn
  import sparse_cnn_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             feature_in_valid,
  input  logic [WORD_LENGTH-1:0]           in_feature,
  input  logic [MAX_NNZ*WORD_LENGTH-1:0]   pe_input_weight_value,
  input  logic [MAX_NNZ*WORD_LENGTH-1:0]   pe_input_weight_rows,
  input  logic [MAX_NNZ*WORD_LENGTH-1:0]   pe_input_weight_cols,
  input  logic [15:0]                      weight_valid_num,
  output logic                             out_valid,
  output logic [NUM_OUT*ACC_WIDTH-1:0]     out_feature
);

  cnt_t row_q, row_d;
  cnt_t col_q, col_d;
  logic out_valid_q, out_valid_d;
  acc_t acc_q [NUM_OUT];
  acc_t acc_d [NUM_OUT];

  logic               frame_start;
  logic               frame_last;
  logic [MAX_NNZ-1:0] pe_hit;
  idx_t               pe_idx  [MAX_NNZ];
  acc_t               pe_prod [MAX_NNZ];

  assign frame_start = (row_q == '0) && (col_q == '0);
  assign frame_last  = (row_q == cnt_t'(IMAGE_SIZE-1)) && (col_q == cnt_t'(IMAGE_SIZE-1));

  // One PE per weight slot; slots at or beyond weight_valid_num are disabled,
  // which also caps the count at MAX_NNZ without any out-of-range access.
  for (genvar k = 0; k < MAX_NNZ; k++) begin : g_pe
    logic [IDX_W-1:0]     idx_w;
    logic [ACC_WIDTH-1:0] prod_w;

    sparse_cnn_pe u_pe (
      .en_i     (weight_valid_num > 16'(k)),
      .pixel_i  (in_feature),
      .weight_i (pe_input_weight_value[WORD_LENGTH*k +: WORD_LENGTH]),
      .row_i    (pe_input_weight_rows[WORD_LENGTH*k +: WORD_LENGTH]),
      .col_i    (pe_input_weight_cols[WORD_LENGTH*k +: WORD_LENGTH]),
      .r_i      (row_q),
      .c_i      (col_q),
      .prod_o   (prod_w),
      .idx_o    (idx_w),
      .hit_o    (pe_hit[k])
    );

    assign pe_idx[k]  = idx_w;
    assign pe_prod[k] = acc_t'(prod_w);
  end

  // Raster position of the next pixel to be accepted
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (feature_in_valid) begin
      if (col_q == cnt_t'(IMAGE_SIZE-1)) begin
        col_d = '0;
        row_d = frame_last ? '0 : row_q + cnt_t'(1);
      end else begin
        col_d = col_q + cnt_t'(1);
      end
    end
  end

  // Result flag: set by the last pixel, cleared by the first pixel of the next frame
  always_comb begin
    out_valid_d = out_valid_q;
    if (feature_in_valid) begin
      if (frame_last) begin
        out_valid_d = 1'b1;
      end else if (frame_start) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Scatter-accumulate: the first pixel reloads the base value, then every hitting
  // PE adds in sequence so slots sharing a target are summed rather than dropped.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      acc_d[i] = acc_q[i];
    end
    if (feature_in_valid) begin
      if (frame_start) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          acc_d[i] = ACC_INIT;
        end
      end
      for (int k = 0; k < MAX_NNZ; k++) begin
        if (pe_hit[k]) begin
          acc_d[pe_idx[k]] = acc_d[pe_idx[k]] + pe_prod[k];
        end
      end
    end
  end

  // State registers; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        acc_q[i] <= ACC_INIT;
      end
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NUM_OUT; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;

  // The accumulator array is the output; it only holds a result while out_valid is set
  for (genvar w = 0; w < NUM_OUT; w++) begin : g_out
    assign out_feature[ACC_WIDTH*w +: ACC_WIDTH] = acc_q[w];
  end

endmodule

// File: tb/tb_sparse_cnn.sv
// Bench for sparse_cnn: gather-form reference convolution plus out_valid timing model.
// Directed frames: dense, impulse, ramp/identity, ignored and duplicate taps, gaps, reset.
// Compare process runs on every falling edge.
module tb_sparse_cnn;

  localparam int NO  = 576;
  localparam int FW  = NO * 16;
`ifdef SPARSE_CNN_BIAS_EN
  localparam logic [15:0] INIT_TB = 16'd14;
`else
  localparam logic [15:0] INIT_TB = 16'd0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            feature_in_valid;
  logic [7:0]      in_feature;
  logic [223:0]    wval_bus;
  logic [223:0]    wrow_bus;
  logic [223:0]    wcol_bus;
  logic [15:0]     weight_valid_num;
  logic            out_valid;
  logic [FW-1:0]   out_feature;

  sparse_cnn dut (
    .clk                   (clk),
    .rst                   (rst),
    .feature_in_valid      (feature_in_valid),
    .in_feature            (in_feature),
    .pe_input_weight_value (wval_bus),
    .pe_input_weight_rows  (wrow_bus),
    .pe_input_weight_cols  (wcol_bus),
    .weight_valid_num      (weight_valid_num),
    .out_valid             (out_valid),
    .out_feature           (out_feature)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  int img [28][28];
  int wv [28];
  int wr [28];
  int wc [28];
  int nnz_set;
  int pix_idx;
  logic exp_vld;
  logic [FW-1:0] exp_feat;
  logic [FW-1:0] pend_feat;

  logic [7:0] dense_k [25] = '{8'h01, 8'hff, 8'hfd, 8'hf8, 8'hf9, 8'h04, 8'h02, 8'hfc, 8'hfc, 8'hf5,
                               8'h06, 8'h07, 8'h03, 8'hff, 8'hff, 8'h01, 8'h08, 8'h09, 8'h09, 8'h05,
                               8'hfd, 8'h02, 8'h03, 8'h09, 8'h08};

  // Gather-form reference: each output sums its own window of taps
  function automatic logic [FW-1:0] model_conv();
    logic [FW-1:0] v;
    int s;
    v = '0;
    for (int oy = 0; oy < 24; oy++) begin
      for (int ox = 0; ox < 24; ox++) begin
        s = 0;
        for (int k = 0; k < 28; k++) begin
          if (k < nnz_set && wr[k] < 5 && wc[k] < 5)
            s += wv[k] * img[oy + wr[k]][ox + wc[k]];
        end
        v[16*(oy*24+ox) +: 16] = 16'(s) + INIT_TB;
      end
    end
    return v;
  endfunction

  task automatic setup_frame();
    for (int k = 0; k < 28; k++) begin
      wval_bus[8*k +: 8] = 8'(wv[k]);
      wrow_bus[8*k +: 8] = 8'(wr[k]);
      wcol_bus[8*k +: 8] = 8'(wc[k]);
    end
    weight_valid_num = 16'(nnz_set);
    pend_feat = model_conv();
  endtask

  task automatic set_dense();
    for (int k = 0; k < 28; k++) begin
      if (k < 25) begin
        wv[k] = $signed(dense_k[k]);
        wr[k] = k / 5;
        wc[k] = k % 5;
      end else begin
        wv[k] = int'($urandom_range(0, 255)) - 128;
        wr[k] = int'($urandom_range(0, 7));
        wc[k] = int'($urandom_range(0, 7));
      end
    end
    nnz_set = 25;
  endtask

  task automatic set_garbage();
    for (int k = 0; k < 28; k++) begin
      wv[k] = int'($urandom_range(1, 127));
      wr[k] = int'($urandom_range(0, 4));
      wc[k] = int'($urandom_range(0, 4));
    end
  endtask

  task automatic img_ones();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1;
  endtask

  task automatic img_ramp();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = (r*28 + c) % 256;
  endtask

  task automatic img_impulse();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 0;
    img[4][4] = 255;
  endtask

  // Drive one pixel and advance the timing model past the accepting edge
  task automatic push(input int p);
    feature_in_valid = 1'b1;
    in_feature = 8'(p);
    @(posedge clk);
    #1;
    feature_in_valid = 1'b0;
    if (pix_idx == 0) begin
      exp_feat = pend_feat;
      exp_vld = 1'b0;
    end
    if (pix_idx == 783) exp_vld = 1'b1;
    pix_idx = (pix_idx + 1) % 784;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int gap, input int npix);
    int n;
    n = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (n < npix) begin
          push(img[r][c]);
          if (gap != 0) idle(1);
        end
        n++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_idx = 0;
    exp_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk16(input string name, input int elem, input logic [15:0] expv);
    logic [15:0] got;
    got = out_feature[16*elem +: 16];
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: elem %0d got %h expected %h", name, elem, got, expv);
    end
  endtask

  task automatic chk1(input string name, input logic expv);
    checks++;
    if (out_valid !== expv) begin
      errors++;
      $display("FAIL %s: out_valid got %b expected %b", name, out_valid, expv);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (out_valid !== exp_vld) begin
      errors++;
      $display("FAIL valid_timing @%0t: got %b expected %b", $time, out_valid, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (out_feature !== exp_feat) begin
        errors++;
        for (int w = 0; w < NO; w++) begin
          if (out_feature[16*w +: 16] !== exp_feat[16*w +: 16]) begin
            $display("FAIL feature @%0t: elem %0d got %h expected %h", $time, w,
                     out_feature[16*w +: 16], exp_feat[16*w +: 16]);
            break;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    feature_in_valid = 1'b0;
    in_feature = '0;
    wval_bus = '0;
    wrow_bus = '0;
    wcol_bus = '0;
    weight_valid_num = '0;
    pix_idx = 0;
    exp_vld = 1'b0;
    exp_feat = '0;
    pend_feat = '0;
    nnz_set = 0;
    for (int k = 0; k < 28; k++) begin
      wv[k] = 0; wr[k] = 0; wc[k] = 0;
    end
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk1("reset_valid", 1'b0);
    chk16("reset_acc0", 0, INIT_TB);
    chk16("reset_acc575", 575, INIT_TB);

    // Dense kernel on all-ones image: every output is the weight sum 34
    set_dense(); img_ones(); setup_frame();
    run_frame(0, 784);
    chk1("dense_valid", 1'b1);
    chk16("dense_first", 0, 16'h0022 + INIT_TB);
    chk16("dense_last", 575, 16'h0022 + INIT_TB);

    // Impulse back-to-back: taps appear mirrored around (4,4)
    img_impulse(); setup_frame();
    run_frame(0, 784);
    chk16("impulse_00", 0, 16'h07F8 + INIT_TB);
    chk16("impulse_30", 3*24+0, 16'hF50B + INIT_TB);
    chk16("impulse_31", 3*24+1, 16'hFC04 + INIT_TB);
    chk16("impulse_far", 10*24+10, INIT_TB);

    // Single tap of 2 at (0,0) on ramp; remaining slots are garbage
    set_garbage(); wv[0] = 2; wr[0] = 0; wc[0] = 0; nnz_set = 1;
    img_ramp(); setup_frame();
    run_frame(0, 784);
    chk16("ramp_11", 1*24+1, 16'd58 + INIT_TB);
    chk16("ramp_2323", 23*24+23, 16'd310 + INIT_TB);

    // Out-of-kernel tap ignored, duplicate taps summed: 3 + (-1) = 2 at (0,0)
    set_garbage(); nnz_set = 3;
    wv[0] = 3;  wr[0] = 0; wc[0] = 0;
    wv[1] = 7;  wr[1] = 5; wc[1] = 1;
    wv[2] = -1; wr[2] = 0; wc[2] = 0;
    setup_frame();
    run_frame(0, 784);
    chk16("dup_25", 2*24+5, 16'd122 + INIT_TB);

    // No active slots
    set_garbage(); nnz_set = 0; img_ones(); setup_frame();
    run_frame(0, 784);
    chk16("nnz0", 100, INIT_TB);

    // Count above MAX_NNZ with all-zero weights
    for (int k = 0; k < 28; k++) wv[k] = 0;
    nnz_set = 40; setup_frame();
    run_frame(0, 784);
    chk16("nnz40", 300, INIT_TB);

    // Gapped dense frame, then a quiet hold period
    set_dense(); img_ones(); setup_frame();
    run_frame(1, 784);
    chk16("gapped", 200, 16'h0022 + INIT_TB);
    idle(5);
    chk1("hold_valid", 1'b1);

    // Reset after 100 pixels, replay, then a back-to-back frame
    img_ramp(); setup_frame();
    run_frame(0, 100);
    do_reset();
    chk1("midreset_valid", 1'b0);
    run_frame(0, 784);
    chk1("replay_valid", 1'b1);
    img_ones(); setup_frame();
    run_frame(0, 784);
    chk16("b2b_last", 575, 16'h0022 + INIT_TB);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
